// File: rtl/osnt_bram_pipe_if.sv
// Access bus between the BRAM controller / replay engine and osnt_bram_pipe.
// The master issues accesses and clear requests; the slave returns read data and busy.
interface osnt_bram_pipe_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 736,
  parameter int WE_WIDTH   = DATA_WIDTH / 32
);

  logic                  bram_en;
  logic [WE_WIDTH-1:0]   bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wrdata;
  logic [DATA_WIDTH-1:0] bram_rddata;
  logic                  bram_rdvalid;
  logic                  bram_clear;
  logic                  bram_busy;

  modport master (
    output bram_en,
    output bram_we,
    output bram_addr,
    output bram_wrdata,
    output bram_clear,
    input  bram_rddata,
    input  bram_rdvalid,
    input  bram_busy
  );

  modport slave (
    input  bram_en,
    input  bram_we,
    input  bram_addr,
    input  bram_wrdata,
    input  bram_clear,
    output bram_rddata,
    output bram_rdvalid,
    output bram_busy
  );

endinterface

// File: rtl/osnt_bram_pipe.sv
// Single-port UltraRAM store with 32-bit write strobes, 1..3 cycle pipelined read
// and a sequential zero-fill engine that owns the array after reset or on request.
module osnt_bram_pipe #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 736,
  parameter int WE_WIDTH       = DATA_WIDTH / 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             bram_clk,
  input  logic             bram_rstn,
  osnt_bram_pipe_if.slave  bram
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 32) != 0) begin : g_bad_width
    $error("osnt_bram_pipe: DATA_WIDTH must be a multiple of 32");
  end
  if (WE_WIDTH != DATA_WIDTH / 32) begin : g_bad_we
    $error("osnt_bram_pipe: WE_WIDTH must equal DATA_WIDTH/32");
  end
  if ((RD_LATENCY < 1) || (RD_LATENCY > 3)) begin : g_bad_latency
    $error("osnt_bram_pipe: RD_LATENCY must be 1, 2 or 3");
  end

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy_q;

  (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_v;

  logic accept;
  logic clear_we;

  // Array writes are qualified by reset so that holding reset never disturbs contents.
  always_comb begin
    accept   = bram_rstn && bram.bram_en && (state == ST_IDLE);
    clear_we = bram_rstn && (state == ST_CLEAR);
  end

  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy_q   <= (CLEAR_ON_RESET != 0);
      clr_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bram.bram_clear) begin
            state    <= ST_CLEAR;
            busy_q   <= 1'b1;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge bram_clk) begin
    if (clear_we) begin
      mem[clr_addr] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < WE_WIDTH; i++) begin
        if (bram.bram_we[i]) begin
          mem[bram.bram_addr][32*i +: 32] <= bram.bram_wrdata[32*i +: 32];
        end
      end
    end
  end

  // Stage 0 is the array output register (read-first); later stages only advance
  // with a valid token so the output holds its last read value between reads.
  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      for (int unsigned k = 0; k < RD_LATENCY; k++) begin
        pipe_d[k] <= '0;
      end
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      if (accept) begin
        pipe_d[0] <= mem[bram.bram_addr];
      end
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) begin
          pipe_d[k] <= pipe_d[k-1];
        end
      end
    end
  end

  assign bram.bram_rddata  = pipe_d[RD_LATENCY-1];
  assign bram.bram_rdvalid = pipe_v[RD_LATENCY-1];
  assign bram.bram_busy    = busy_q;

endmodule

// File: tb/tb_osnt_bram_pipe.sv
// Bench for osnt_bram_pipe: three instances (read latency 1, 2, 3) share one stimulus
// stream and are compared every cycle against a memory/queue reference model.
module tb_osnt_bram_pipe;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int WW    = DW / 32;
  localparam int DEPTH = 2 ** AW;
  localparam int HMAX  = 8192;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [WW-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wrdata;
  logic          clear;

  logic [DW-1:0] rd_d [3];
  logic [2:0]    rd_v;
  logic [2:0]    busy;

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    osnt_bram_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bif ();

    assign bif.bram_en     = en;
    assign bif.bram_we     = we;
    assign bif.bram_addr   = addr;
    assign bif.bram_wrdata = wrdata;
    assign bif.bram_clear  = clear;
    assign rd_d[g]         = bif.bram_rddata;
    assign rd_v[g]         = bif.bram_rdvalid;
    assign busy[g]         = bif.bram_busy;

    osnt_bram_pipe #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .WE_WIDTH      (WW),
      .RD_LATENCY    (g + 1),
      .CLEAR_ON_RESET(1)
    ) dut (
      .bram_clk (clk),
      .bram_rstn(rstn),
      .bram     (bif.slave)
    );
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, cycles left until the clear releases the
  // array, and a per-edge history of accepted reads and the data they return.
  logic [DW-1:0] m_mem [DEPTH];
  int            busy_left;
  int            cyc;
  int            first_cyc;
  bit            h_v [HMAX];
  logic [DW-1:0] h_d [HMAX];
  logic [DW-1:0] exp_last [3];

  initial begin
    cyc       = 0;
    first_cyc = 1;
    busy_left = DEPTH;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
      first_cyc = cyc + 1;
    end else begin
      cyc = cyc + 1;
      if (cyc >= HMAX) begin
        $display("FAIL model_history: got cycle %0d limit %0d", cyc, HMAX);
        $fatal(1, "history overflow");
      end
      h_v[cyc] = 1'b0;
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
      end else begin
        if (en) begin
          h_v[cyc] = 1'b1;
          h_d[cyc] = m_mem[addr];
          for (int s = 0; s < WW; s++)
            if (we[s]) m_mem[addr][32*s +: 32] = wrdata[32*s +: 32];
        end
        if (clear) begin
          busy_left = DEPTH;
          foreach (m_mem[i]) m_mem[i] = '0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rstn) begin
        exp_last[g] = '0;
        chk("reset_rdvalid", {63'd0, rd_v[g]}, '0);
        chk("reset_rddata", rd_d[g], '0);
        chk("reset_busy", {63'd0, busy[g]}, 64'd1);
      end else begin
        int  idx;
        bit  ev;
        idx = cyc - g;
        ev  = (idx >= first_cyc) ? h_v[idx] : 1'b0;
        if (ev) exp_last[g] = h_d[idx];
        chk($sformatf("rdvalid_L%0d", g + 1), {63'd0, rd_v[g]}, {63'd0, ev});
        chk($sformatf("rddata_L%0d", g + 1), rd_d[g], exp_last[g]);
        chk($sformatf("busy_L%0d", g + 1), {63'd0, busy[g]}, {63'd0, (busy_left > 0)});
      end
    end
  end

  // Capture of completed reads for the hand-computed checks.
  logic [DW-1:0] d1[$], d2[$], d3[$];
  int            c1[$], c2[$], c3[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (rd_v[0]) begin d1.push_back(rd_d[0]); c1.push_back(cyc); end
      if (rd_v[1]) begin d2.push_back(rd_d[1]); c2.push_back(cyc); end
      if (rd_v[2]) begin d3.push_back(rd_d[2]); c3.push_back(cyc); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WW-1:0] w);
    en = 1'b1; addr = a; wrdata = d; we = w;
    step();
    en = 1'b0; we = '0;
  endtask

  task automatic flush_q();
    repeat (5) step();
    d1.delete(); d2.delete(); d3.delete();
    c1.delete(); c2.delete(); c3.delete();
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy[1] && n < 100) begin
      clear = (n == 5);
      if (n == 2) begin en = 1'b1; addr = 4'd2; wrdata = 64'h77; we = 2'b11; end
      else if (n == 3) begin en = 1'b1; addr = 4'd2; we = 2'b00; end
      else begin en = 1'b0; we = '0; end
      step();
      n++;
    end
    en = 1'b0; we = '0; clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int a0;
    n_chk = 0; n_fail = 0;
    rstn = 1'b0; en = 1'b0; we = '0; addr = '0; wrdata = '0; clear = 1'b0;
    repeat (3) step();

    // Post-reset clear, then all-zero reads.
    rstn = 1'b1;
    busy_len(n);
    chk("post_reset_busy_cycles", n, 16);
    flush_q();
    for (int i = 0; i < DEPTH; i++) acc(i[AW-1:0], '0, '0);
    repeat (5) step();
    chk("post_reset_read_count", d2.size(), 16);
    foreach (d2[i]) chk("post_reset_read_zero", d2[i], 64'h0);
    flush_q();

    // Strobed writes.
    acc(4'd3, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11);
    acc(4'd3, 64'h1111_2222_3333_4444, 2'b01);
    acc(4'd3, 64'h0, 2'b00);
    repeat (4) step();
    chk("strobe_count", d2.size(), 3);
    chk("strobe_first_old", d2[0], 64'h0);
    chk("strobe_second_old", d2[1], 64'hAAAA_BBBB_CCCC_DDDD);
    chk("strobe_merge", d2[2], 64'hAAAA_BBBB_3333_4444);

    // Read-first and back-to-back pipelining.
    acc(4'd5, 64'h5, 2'b11);
    flush_q();
    acc(4'd5, 64'h6, 2'b11);
    acc(4'd5, 64'h0, 2'b00);
    acc(4'd6, 64'h0, 2'b00);
    repeat (4) step();
    chk("rf_count", d2.size(), 3);
    chk("rf_old_data", d2[0], 64'h5);
    chk("rf_new_data", d2[1], 64'h6);
    chk("rf_addr6", d2[2], 64'h0);
    chk("rf_contig_1", c2[1], c2[0] + 1);
    chk("rf_contig_2", c2[2], c2[0] + 2);

    // Clear mid-stream with accesses and a second clear during busy.
    for (int i = 0; i < DEPTH; i++) acc(i[AW-1:0], 64'hFF, 2'b11);
    flush_q();
    clear = 1'b1;
    step();
    clear = 1'b0;
    busy_len(n);
    chk("clear_busy_cycles", n, 16);
    repeat (3) step();
    chk("clear_no_rdvalid_when_busy", d2.size(), 0);
    for (int i = 0; i < DEPTH; i++) acc(i[AW-1:0], '0, '0);
    repeat (5) step();
    chk("after_clear_count", d2.size(), 16);
    foreach (d2[i]) chk("after_clear_zero", d2[i], 64'h0);
    flush_q();

    // Reset in the middle of a clear.
    acc(4'd4, 64'h1234, 2'b11);
    acc(4'd4, 64'h0, 2'b00);
    repeat (3) step();
    chk("pre_reset_rddata", rd_d[1], 64'h1234);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    #1 rstn = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("async_rdvalid", {63'd0, rd_v[g]}, 64'h0);
      chk("async_rddata", rd_d[g], 64'h0);
      chk("async_busy", {63'd0, busy[g]}, 64'h1);
    end
    repeat (2) step();
    rstn = 1'b1;
    busy_len(n);
    chk("reset_restart_busy_cycles", n, 16);
    flush_q();

    // Latency sweep: 16 back-to-back reads of distinct words.
    for (int i = 0; i < DEPTH; i++) acc(i[AW-1:0], 64'hC0DE_0000_0000_0000 + 64'(i), 2'b11);
    flush_q();
    a0 = cyc + 1;
    for (int i = 0; i < DEPTH; i++) acc(i[AW-1:0], '0, '0);
    repeat (5) step();
    chk("sweep_L1_count", d1.size(), 16);
    chk("sweep_L3_count", d3.size(), 16);
    if (d1.size() == 16 && d3.size() == 16) begin
      chk("sweep_L1_start", c1[0], a0);
      chk("sweep_L3_start", c3[0], a0 + 2);
      for (int i = 0; i < DEPTH; i++) begin
        chk("sweep_L1_cycle", c1[i], a0 + i);
        chk("sweep_L3_cycle", c3[i], a0 + 2 + i);
        chk("sweep_L1_data", d1[i], 64'hC0DE_0000_0000_0000 + 64'(i));
        chk("sweep_L3_data", d3[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      end
    end
    flush_q();

    // Randomised traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(3) != 0);
      addr   = AW'($urandom);
      we     = WW'($urandom);
      wrdata = {$urandom, $urandom};
      clear  = ($urandom_range(63) == 0);
      step();
    end
    en = 1'b0; we = '0; clear = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/osnt_bram_pipe.md
Name: osnt_bram_pipe

Overview:
Parametrised single-port UltraRAM/BRAM store for OSNT packet replay/capture buffers. Successor to the basic 1-cycle memory. Adds:
- 32-bit word write strobes
- configurable read latency of 1–3 cycles, with a read-valid output
- a sequential clear engine that zero-fills the memory after reset or on request.

Sits between the AXI BRAM controller/replay engine and the memory array.

Parameters:
- ADDR_WIDTH, 14, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 736, word width. Must be a multiple of 32 (elaboration error otherwise).
- WE_WIDTH, DATA_WIDTH/32, number of write strobes; each covers 32 bits.
- RD_LATENCY, 1, cycles from accepted read to data. Legal 1..3; others cause an elaboration error.
- CLEAR_ON_RESET, 1, 1 = zero-fill the entire memory after reset deassertion.

Ports:
- bram_clk  in  1  clock.
- bram_rstn  in  1  reset, asynchronous, active-low.
- bram_en  in  1  access enable.
- bram_we  in  WE_WIDTH  strobe i writes bits [32i+31:32i].
- bram_addr  in  ADDR_WIDTH  word address.
- bram_wrdata  in  DATA_WIDTH  write data.
- bram_rddata  out  DATA_WIDTH  read data.
- bram_rdvalid  out  1  one-cycle pulse; bram_rddata is valid this cycle.
- bram_clear  in  1  pulse to request a full zero-fill.
- bram_busy  out  1  high while the clear engine owns the array.

Behaviour:
- Reset (bram_rstn=0):
  - bram_rddata=0, bram_rdvalid=0, all pipeline stages and valid flags cleared, clear address=0.
  - bram_busy=1 if CLEAR_ON_RESET, else 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET, else IDLE.
  - Array contents are not touched by reset itself.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when bram_clear=1 (sampled on the clock edge). Clear address loads 0. bram_busy rises the next cycle.
  - CLEAR: each cycle writes all-zero to mem[clr_addr], then clr_addr++.
  - CLEAR exit: on the cycle that writes address 2**ADDR_WIDTH-1, clr_addr wraps to 0, FSM returns to IDLE, and bram_busy falls the following cycle.
  - A full clear takes exactly 2**ADDR_WIDTH cycles.
  - bram_clear while in CLEAR is ignored; the clear does not restart.
  - Reset asserted mid-clear aborts it. If CLEAR_ON_RESET=1 the clear restarts from address 0 after deassertion; otherwise the memory is left partially cleared.
- User access is accepted only when bram_en=1 and the FSM is in IDLE.
  - While busy, user accesses are dropped: no write, no read, no rdvalid. The caller must wait for bram_busy=0.
- Write: for each strobe i set, mem[addr][32i+31:32i] <= wrdata slice. Unstrobed slices are preserved.
- Read: every accepted access is a read, including writes.
  - Read-first semantics: a same-address write returns the old contents.
  - The array output register is stage 1. RD_LATENCY-1 further register stages follow.
  - bram_rddata and bram_rdvalid appear exactly RD_LATENCY cycles after the accepting edge.
  - Fully pipelined: one access per cycle, back-to-back, no bubbles.
- bram_rddata holds its last value when no read completes. It is not zeroed; only bram_rdvalid deasserts.
- Reads launched before bram_clear is accepted still complete with the correct rdvalid timing. The clear starts one cycle after acceptance, so no ordering hazard exists.
- Infer the array with ram_style "ultra". Pipeline registers stay outside the array, with no reset on the array itself.

Test Plan:
Bench parameters: ADDR_WIDTH=4, DATA_WIDTH=64, RD_LATENCY=2, CLEAR_ON_RESET=1 unless noted.
1. Post-reset clear: release bram_rstn -> bram_busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 return 64'h0 with rdvalid exactly 2 cycles after each accepted read.
2. Strobed write: write addr 3, data 64'hAAAA_BBBB_CCCC_DDDD, we=2'b11. Then write addr 3, data 64'h1111_2222_3333_4444, we=2'b01. Read addr 3 -> 64'hAAAA_BBBB_3333_4444.
3. Read-first / pipelining: with addr 5 = 64'h5, on consecutive cycles write addr 5 = 64'h6, then read 5, then read 6 -> rdvalid high for 3 consecutive cycles with data 64'h5, 64'h6, mem[6].
4. Clear request mid-stream: write all addresses with 64'hFF, pulse bram_clear, and issue a write plus a read during busy. Results required:
   - no rdvalid for the access made during busy
   - busy high for 16 cycles
   - all addresses read 0 afterwards
   - a second bram_clear during busy does not extend busy beyond 16 cycles.
5. Reset mid-clear: assert bram_rstn low at clear cycle 7 -> rdvalid=0 and rddata=0 immediately (asynchronous). After release, busy is high for a full 16 cycles again.
6. Latency sweep: RD_LATENCY=1 and RD_LATENCY=3, with 16 back-to-back reads -> 16 contiguous rdvalid pulses starting 1 or 3 cycles after the first accepted read, data in address order.
